// File: rtl/box_position_ctrl.sv
// Push-button to box-position controller: synchronizes, debounces and auto-repeats
// the four direction buttons, then moves the box by STEP at frame boundaries only.
module box_position_ctrl #(
  parameter int DEBOUNCE_CNT = 250000,
  parameter int STEP         = 8,
  parameter int BOX_SIZE     = 32,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int X_INIT       = 304,
  parameter int Y_INIT       = 224,
  parameter int REPEAT_TICKS = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       frame_start,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       moving
);

  localparam int DB_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int HOLD_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_TICKS);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);

  // Direction bit order used throughout: {U, D, L, R}
  localparam int IDX_U = 3;
  localparam int IDX_D = 2;
  localparam int IDX_L = 1;
  localparam int IDX_R = 0;

  typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

  state_t state, state_nxt;

  logic [3:0] btn_p0, btn_p1;
  logic       tick_p0, tick_p1, tick_p2;
  logic       tick_edge;
  logic [3:0] deb, deb_p;
  logic [DB_W-1:0]   db_cnt   [4];
  logic [HOLD_W-1:0] hold     [4];
  logic [HOLD_W-1:0] hold_inc [4];
  logic [3:0] req;
  logic [3:0] pend;
  logic [9:0] x_nxt, y_nxt;

  function automatic logic [9:0] sat_dec(input logic [9:0] pos);
    logic [10:0] p;
    p = {1'b0, pos};
    sat_dec = (p < STEP_W) ? 10'd0 : 10'(p - STEP_W);
  endfunction

  function automatic logic [9:0] sat_inc(input logic [9:0] pos, input logic [10:0] lim);
    logic [10:0] up;
    up = {1'b0, pos} + STEP_W;
    sat_inc = (up > lim) ? 10'(lim) : 10'(up);
  endfunction

  function automatic logic [9:0] move_axis(input logic [9:0] pos, input logic dec,
                                           input logic inc, input logic [10:0] lim);
    move_axis = pos;
    if (dec && !inc)
      move_axis = sat_dec(pos);
    else if (inc && !dec)
      move_axis = sat_inc(pos, lim);
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous tick for edge detect
  always_ff @(posedge clk) begin
    if (!clr) begin
      btn_p0  <= '0;
      btn_p1  <= '0;
      tick_p0 <= 1'b0;
      tick_p1 <= 1'b0;
      tick_p2 <= 1'b0;
    end else begin
      btn_p0  <= {btn_u, btn_d, btn_l, btn_r};
      btn_p1  <= btn_p0;
      tick_p0 <= tick;
      tick_p1 <= tick_p0;
      tick_p2 <= tick_p1;
    end
  end

  assign tick_edge = tick_p1 & ~tick_p2;

  // Debounce and hold counting per direction
  always_ff @(posedge clk) begin
    if (!clr) begin
      deb   <= '0;
      deb_p <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
        hold[i]   <= '0;
      end
    end else begin
      deb_p <= deb;
      for (int i = 0; i < 4; i++) begin
        if (btn_p1[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= btn_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
        if (!deb[i])
          hold[i] <= '0;
        else if (tick_edge)
          hold[i] <= hold_inc[i];
      end
    end
  end

  // A request is a fresh debounced press, or a tick edge once the hold has saturated
  always_comb begin
    req = '0;
    for (int i = 0; i < 4; i++) begin
      hold_inc[i] = (hold[i] == HOLD_MAX) ? HOLD_MAX : hold[i] + HOLD_W'(1);
      req[i] = (deb[i] & ~deb_p[i]) |
               (deb[i] & tick_edge & (hold_inc[i] == HOLD_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (!clr)
      pend <= '0;
    else if (state == APPLY)
      pend <= req;
    else
      pend <= pend | req;
  end

  always_ff @(posedge clk) begin
    if (!clr)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend) state_nxt = ARMED;
      ARMED:   if (frame_start) state_nxt = APPLY;
      APPLY:   state_nxt = (|req) ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_nxt = move_axis(box_x, pend[IDX_L], pend[IDX_R], X_MAX);
    y_nxt = move_axis(box_y, pend[IDX_U], pend[IDX_D], Y_MAX);
  end

  // Position registers update only on the edge that ends the APPLY cycle
  always_ff @(posedge clk) begin
    if (!clr) begin
      box_x <= 10'(X_INIT);
      box_y <= 10'(Y_INIT);
    end else if (state == APPLY) begin
      box_x <= x_nxt;
      box_y <= y_nxt;
    end
  end

  assign moving = (state != IDLE);

endmodule

// File: doc/box_position_ctrl.md
Name: box_position_ctrl

Overview:
- Upstream stage of the VGA pixel output logic: turns raw push-buttons into a bounded on-screen box position (box_x, box_y) that the output stage draws.
- Synchronizes, debounces and edge-detects btnU/D/L/R, and auto-repeats while a button is held, paced by the slow tick from the clock divider.
- Applies moves only at frame boundaries to avoid tearing.
- Runs on the 25 MHz pixel clock.

Parameters:
- DEBOUNCE_CNT, 250000: consecutive stable samples before a button level is accepted (10 ms at 25 MHz).
- STEP, 8: pixels moved per request.
- BOX_SIZE, 32: box edge length in pixels.
- H_ACTIVE, 640: visible width.
- V_ACTIVE, 480: visible height.
- X_INIT, 304: reset x (top-left corner).
- Y_INIT, 224: reset y.
- REPEAT_TICKS, 4: tick edges a button must be held before auto-repeat starts.

Ports:
- clk  input  1  pixel clock; the only clock.
- clr  input  1  reset, synchronous, active-low (clr=0 resets on the next clk edge).
- tick  input  1  slow pacing level from the clock divider; asynchronous to clk.
- frame_start  input  1  one-clk pulse at the start of vertical blanking.
- btn_u, btn_d, btn_l, btn_r  input  1 each  raw asynchronous buttons, active-high.
- box_x  output  10  box left edge, range 0..H_ACTIVE-BOX_SIZE.
- box_y  output  10  box top edge, range 0..V_ACTIVE-BOX_SIZE.
- moving  output  1  high while a move is pending or being applied.

Behaviour:
- Reset values: box_x=X_INIT, box_y=Y_INIT, moving=0.
- Reset also clears all synchronizer flops, debounced levels, debounce counters, hold counters, pending flags and the tick edge flop.
- Synchronizers: tick and each button pass through a 2-flop synchronizer. A tick edge is a 0->1 transition on the synchronized tick.
- Debounce (per button):
  - Counter clears whenever the synchronized raw level equals the debounced level.
  - Otherwise it increments; when it reaches DEBOUNCE_CNT-1, the debounced level takes the raw level and the counter clears.
  - Width is ceil(log2(DEBOUNCE_CNT)).
- Press request: a debounced 0->1 raises one request for that direction.
- Auto-repeat:
  - While debounced high, each tick edge increments the hold counter, saturating at REPEAT_TICKS.
  - Every tick edge at which the counter equals REPEAT_TICKS (after incrementing) raises one request.
  - The hold counter clears when the debounced level goes low.
- Pending flags: one sticky flag per direction, set by a request. Multiple requests within one frame collapse to a single STEP.
- FSM states: IDLE, ARMED, APPLY.
  - IDLE -> ARMED when any flag is set.
  - ARMED -> APPLY on frame_start.
  - APPLY -> IDLE after one cycle, or -> ARMED if new requests arrived during APPLY.
  - frame_start in IDLE is ignored.
- Apply: on the APPLY cycle, the flags are snapshotted and cleared, and box_x/box_y register their new values. The outputs therefore change on the edge ending the APPLY cycle, 2 clk after the frame_start edge.
- Request arriving in the APPLY cycle: it sets its flag after the snapshot clear and is retained for the next frame.
- X arithmetic (11-bit intermediates):
  - L only: x = (x < STEP) ? 0 : x-STEP.
  - R only: x = (x+STEP > H_ACTIVE-BOX_SIZE) ? H_ACTIVE-BOX_SIZE : x+STEP.
  - L and R both pending: no x change.
- Y arithmetic: same rules with U (decrement), D (increment) and V_ACTIVE.
- X and Y are independent, so diagonal moves are allowed.
- moving = (state != IDLE).
- Reset mid-operation: everything returns to reset values. A button held through reset is seen as a new press only after DEBOUNCE_CNT stable samples.

Test Plan (DEBOUNCE_CNT=4, REPEAT_TICKS=4, STEP=8, BOX_SIZE=32):
- clr=0 for 3 clk, then clr=1 -> box_x=304, box_y=224, moving=0. A frame_start with no buttons pressed leaves both unchanged.
- btn_r high for 10 clk, then frame_start -> moving=1 before frame_start; box_x=312 two clk after frame_start; moving=0 afterwards. A separate 2-clk btn_r glitch followed by frame_start -> no change.
- Clamping:
  - Hold btn_l and issue 40 frame_starts with ticks -> box_x steps down by 8 and reaches 0; further frames stay at 0.
  - Same with btn_d -> box_y saturates at 448.
  - Same with btn_r -> box_x saturates at 608.
- Simultaneous directions:
  - btn_l and btn_r pressed together, then frame_start -> box_x unchanged.
  - btn_u and btn_r together, then frame_start -> box_x=312, box_y=216.
- Auto-repeat: hold btn_u, with one frame_start after the press and after each of 6 tick edges -> requests on the press and on tick edges 4, 5 and 6. Final box_y=224-32=192.
- Timing and reset corner cases:
  - A btn_d press whose debounce completes in the APPLY cycle -> applied at the following frame_start, not lost.
  - clr=0 asserted mid-hold -> box resets to (304,224). After clr=1 with the button still held, a move occurs only after 4 stable clk plus a frame_start.
